// File: rtl/board_reveal_engine.sv
// rtl/board_reveal_engine.sv - captures the placed board, applies reveal/flag commands
// and runs the row-major flood-reveal sweep; tracks revealed count, loss and win.
module board_reveal_engine #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [0:7][0:7][8:0] board_in,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [2:0]           cmd_row,
    input  logic [2:0]           cmd_col,
    output logic [0:7][0:7][8:0] board_out,
    output logic                 busy,
    output logic                 done,
    output logic                 hit_bomb,
    output logic                 win,
    output logic [6:0]           revealed_count,
    output logic [6:0]           mine_count
);
    localparam int B_BOMB = 5;
    localparam int B_REV  = 6;
    localparam int B_FLAG = 7;
    localparam logic [7:0] CELLS = 8'(N * N);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_IDLE,
        S_SWEEP,
        S_OVER
    } state_e;

    state_e               state_q;
    logic [0:7][0:7][8:0] board_q;
    logic [5:0]           idx_q;
    logic                 changed_q;
    logic                 done_q;
    logic                 hit_q;
    logic                 win_q;
    logic [6:0]           rev_q;
    logic [6:0]           mine_q;

    // Load path: scrub status/reserved bits and count bombs inside the N x N window.
    logic [0:7][0:7][8:0] load_board;
    logic [6:0]           load_mines;
    logic                 unused_in;

    always_comb begin
        load_board = '0;
        load_mines = '0;
        unused_in  = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                load_board[r][c][3:0]    = board_in[r][c][3:0];
                load_board[r][c][B_BOMB] = board_in[r][c][B_BOMB];
                unused_in = unused_in ^ (^{board_in[r][c][8:6], board_in[r][c][4]});
                if (r < N && c < N) begin
                    load_mines = load_mines + 7'(board_in[r][c][B_BOMB]);
                end
            end
        end
    end

    logic [8:0] cmd_cell;
    logic       cmd_in_range;
    logic [6:0] rev_inc;

    assign cmd_cell     = board_q[cmd_row][cmd_col];
    assign cmd_in_range = (int'(cmd_row) < N) && (int'(cmd_col) < N);
    assign rev_inc      = ({1'b0, rev_q} == CELLS) ? rev_q : rev_q + 7'd1;

    // Sweep cell: revealable when some in-bounds neighbour is an opened zero cell.
    logic [2:0] sw_row;
    logic [2:0] sw_col;
    logic [8:0] sw_cell;
    logic       sw_seed;
    logic       sw_reveal;

    assign sw_row  = idx_q[5:3];
    assign sw_col  = idx_q[2:0];
    assign sw_cell = board_q[sw_row][sw_col];

    always_comb begin
        sw_seed = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (board_q[r][c][B_REV] && !board_q[r][c][B_BOMB] &&
                    board_q[r][c][3:0] == 4'd0 &&
                    (r - int'(sw_row)) <= 1 && (int'(sw_row) - r) <= 1 &&
                    (c - int'(sw_col)) <= 1 && (int'(sw_col) - c) <= 1) begin
                    sw_seed = 1'b1;
                end
            end
        end
    end

    assign sw_reveal = (int'(sw_row) < N) && (int'(sw_col) < N) &&
                       !sw_cell[B_REV] && !sw_cell[B_FLAG] && !sw_cell[B_BOMB] && sw_seed;

    // Completion decode: fin marks every done except the bomb hit, which can never win.
    logic       cmd_go;
    logic       fin;
    logic       fin_win;
    logic       bomb_hit;
    logic [6:0] fin_rev;

    assign cmd_go = (state_q == S_IDLE) && cmd_valid && !load;

    always_comb begin
        fin      = 1'b0;
        fin_rev  = rev_q;
        bomb_hit = 1'b0;
        if (cmd_go) begin
            if (!cmd_in_range || cmd_op || cmd_cell[B_REV] || cmd_cell[B_FLAG]) begin
                fin = 1'b1;
            end else if (cmd_cell[B_BOMB]) begin
                bomb_hit = 1'b1;
            end else begin
                fin_rev = rev_inc;
                fin     = (cmd_cell[3:0] != 4'd0);
            end
        end else if (state_q == S_SWEEP && idx_q == 6'd63 && !changed_q && !sw_reveal) begin
            fin = 1'b1;
        end
    end

    assign fin_win = fin && !hit_q && (({1'b0, fin_rev} + {1'b0, mine_q}) == CELLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            board_q   <= '0;
            idx_q     <= '0;
            changed_q <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            win_q     <= 1'b0;
            rev_q     <= '0;
            mine_q    <= '0;
        end else begin
            done_q <= fin || bomb_hit;
            if (load && state_q != S_SWEEP) begin
                board_q <= load_board;
                mine_q  <= load_mines;
                rev_q   <= '0;
                hit_q   <= 1'b0;
                win_q   <= 1'b0;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cmd_valid && cmd_in_range) begin
                            if (cmd_op) begin
                                if (!cmd_cell[B_REV]) begin
                                    board_q[cmd_row][cmd_col][B_FLAG] <= ~cmd_cell[B_FLAG];
                                end
                            end else if (!cmd_cell[B_REV] && !cmd_cell[B_FLAG]) begin
                                board_q[cmd_row][cmd_col][B_REV] <= 1'b1;
                                if (cmd_cell[B_BOMB]) begin
                                    hit_q   <= 1'b1;
                                    state_q <= S_OVER;
                                end else begin
                                    rev_q <= rev_inc;
                                    if (cmd_cell[3:0] == 4'd0) begin
                                        state_q   <= S_SWEEP;
                                        idx_q     <= '0;
                                        changed_q <= 1'b0;
                                    end
                                end
                            end
                        end
                    end
                    S_SWEEP: begin
                        if (sw_reveal) begin
                            board_q[sw_row][sw_col][B_REV] <= 1'b1;
                            rev_q <= rev_inc;
                        end
                        idx_q     <= idx_q + 6'd1;
                        changed_q <= (idx_q == 6'd63) ? 1'b0 : (changed_q | sw_reveal);
                        if (idx_q == 6'd63 && !changed_q && !sw_reveal) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
                if (fin_win) begin
                    win_q   <= 1'b1;
                    state_q <= S_OVER;
                end
            end
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q == S_SWEEP);
    assign board_out      = board_q;
    assign done           = done_q;
    assign hit_bomb       = hit_q;
    assign win            = win_q;
    assign revealed_count = rev_q;
    assign mine_count     = mine_q;
endmodule

// File: tb/tb_board_reveal_engine.sv
// tb/tb_board_reveal_engine.sv - directed and randomized bench for board_reveal_engine
// against a cell-array game model evaluated once per clock edge.
module tb_board_reveal_engine;
    localparam int N = 8;
    localparam int M_EMPTY = 0;
    localparam int M_IDLE  = 1;
    localparam int M_SWEEP = 2;
    localparam int M_OVER  = 3;

    typedef logic [0:7][0:7][8:0] board_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    board_t     board_in;
    board_t     board_out;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [2:0] cmd_row;
    logic [2:0] cmd_col;
    logic       busy;
    logic       done;
    logic       hit_bomb;
    logic       win;
    logic [6:0] revealed_count;
    logic [6:0] mine_count;

    always #5 clk = ~clk;

    board_reveal_engine #(.N(N)) dut (
        .clk(clk), .rst(rst), .load(load), .board_in(board_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .board_out(board_out),
        .busy(busy), .done(done), .hit_bomb(hit_bomb), .win(win),
        .revealed_count(revealed_count), .mine_count(mine_count)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] m_cell [8][8];
    logic [8:0] m_fin  [8][8];
    int m_rev, m_fin_rev, m_mine, m_state, m_left, m_sweeps;
    bit m_hit, m_win, m_done;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_board(input string name, input board_t act, input board_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic board_t m_packed();
        board_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = m_cell[r][c];
        return b;
    endfunction

    function automatic board_t build_board(input logic [63:0] bombs, input bit garbage);
        board_t b;
        int cnt;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8 && bombs[(r + dr) * 8 + c + dc])
                            cnt++;
                b[r][c] = '0;
                b[r][c][3:0] = 4'(cnt);
                b[r][c][5] = bombs[r * 8 + c];
                if (garbage) begin
                    b[r][c][8:6] = 3'($urandom);
                    b[r][c][4]   = 1'($urandom);
                end
            end
        end
        return b;
    endfunction

    function automatic bit fin_open(input int r, input int c);
        if (r < 0 || r >= N || c < 0 || c >= N) return 1'b0;
        return m_fin[r][c][6] && !m_fin[r][c][5] && m_fin[r][c][3:0] == 4'd0;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                m_cell[r][c] = '0;
        m_rev = 0; m_mine = 0; m_hit = 0; m_win = 0; m_done = 0;
        m_left = 0; m_state = M_EMPTY;
    endtask

    task automatic m_finish();
        m_done = 1;
        if (m_rev + m_mine == N * N && !m_hit) begin
            m_win = 1;
            m_state = M_OVER;
        end
    endtask

    // Whole flood, sweep by sweep on a copy; the count of sweeps sets the done latency.
    task automatic m_flood();
        bit changed;
        bit seed;
        m_sweeps = 0;
        do begin
            changed = 0;
            m_sweeps++;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (m_fin[r][c][6] || m_fin[r][c][7] || m_fin[r][c][5]) continue;
                    seed = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if ((dr != 0 || dc != 0) && fin_open(r + dr, c + dc)) seed = 1;
                    if (seed) begin
                        m_fin[r][c][6] = 1'b1;
                        m_fin_rev++;
                        changed = 1;
                    end
                end
            end
        end while (changed);
    endtask

    task automatic m_edge();
        logic [8:0] cl;
        m_done = 0;
        if (m_state != M_SWEEP && load) begin
            m_mine = 0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    m_cell[r][c] = {3'b000, board_in[r][c][5], 1'b0, board_in[r][c][3:0]};
                    if (r < N && c < N && board_in[r][c][5]) m_mine++;
                end
            end
            m_rev = 0; m_hit = 0; m_win = 0; m_state = M_IDLE;
        end else if (m_state == M_IDLE && cmd_valid) begin
            cl = m_cell[cmd_row][cmd_col];
            if (cmd_op) begin
                if (!cl[6]) m_cell[cmd_row][cmd_col][7] = ~cl[7];
                m_finish();
            end else if (cl[6] || cl[7]) begin
                m_finish();
            end else if (cl[5]) begin
                m_cell[cmd_row][cmd_col][6] = 1'b1;
                m_hit = 1; m_done = 1; m_state = M_OVER;
            end else if (cl[3:0] != 4'd0) begin
                m_cell[cmd_row][cmd_col][6] = 1'b1;
                m_rev++;
                m_finish();
            end else begin
                m_fin = m_cell;
                m_fin[cmd_row][cmd_col][6] = 1'b1;
                m_fin_rev = m_rev + 1;
                m_flood();
                m_left = 64 * m_sweeps;
                m_state = M_SWEEP;
            end
        end else if (m_state == M_SWEEP) begin
            m_left--;
            if (m_left == 0) begin
                m_cell = m_fin;
                m_rev = m_fin_rev;
                m_state = M_IDLE;
                m_finish();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) m_reset();
        else m_edge();
    endtask

    always @(negedge clk) begin
        chk("busy", busy, m_state == M_SWEEP);
        chk("cmd_ready", cmd_ready, m_state == M_IDLE);
        chk("done", done, m_done);
        chk("hit_bomb", hit_bomb, m_hit);
        chk("win", win, m_win);
        chk("mine_count", mine_count, m_mine);
        if (m_state != M_SWEEP) begin
            chk("revealed_count", revealed_count, m_rev);
            chk_board("board_out", board_out, m_packed());
        end
    end

    task automatic do_load(input board_t b);
        board_in = b;
        load = 1;
        tick();
        load = 0;
    endtask

    task automatic do_cmd(input bit op, input int r, input int c, output int lat);
        cmd_valid = 1; cmd_op = op; cmd_row = 3'(r); cmd_col = 3'(c);
        tick();
        cmd_valid = 0;
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            tick();
            lat++;
        end
        if (lat >= 1000) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
        end
    endtask

    initial begin
        int lat;
        board_t zero_b;
        board_t one_b;
        logic [63:0] bombs;

        rst = 1; load = 0; cmd_valid = 0; cmd_op = 0; cmd_row = 0; cmd_col = 0;
        board_in = '0;
        m_reset();
        tick();
        tick();
        chk_board("reset_board", board_out, '0);
        chk("reset_ready", cmd_ready, 0);
        chk("reset_rev", revealed_count, 0);
        rst = 0;
        tick();
        cmd_valid = 1;
        tick();
        cmd_valid = 0;
        chk("empty_ignores_cmd", done, 0);

        zero_b = build_board(64'd0, 1'b1);
        do_load(zero_b);
        chk("zero_mines", mine_count, 0);
        chk("ready_after_load", cmd_ready, 1);
        do_cmd(1'b0, 0, 0, lat);
        chk("zero_latency", lat, 128);
        chk("zero_sweeps", m_sweeps, 2);
        chk("zero_rev", revealed_count, 64);
        chk("zero_win", win, 1);
        chk("zero_over_ready", cmd_ready, 0);

        one_b = build_board(64'd1 << 27, 1'b1);
        do_load(one_b);
        chk("one_mines", mine_count, 1);
        do_cmd(1'b0, 2, 3, lat);
        chk("single_latency", lat, 0);
        chk("single_rev", revealed_count, 1);
        chk("single_cell", board_out[2][3], 9'h041);
        chk("single_busy", busy, 0);

        do_cmd(1'b0, 3, 3, lat);
        chk("bomb_latency", lat, 0);
        chk("bomb_hit", hit_bomb, 1);
        chk("bomb_win", win, 0);
        cmd_valid = 1; cmd_op = 0; cmd_row = 0; cmd_col = 0;
        repeat (3) tick();
        cmd_valid = 0;
        chk("over_ignores_rev", revealed_count, 1);
        chk("over_ignores_done", done, 0);
        do_load(one_b);
        chk("reload_hit", hit_bomb, 0);
        chk("reload_ready", cmd_ready, 1);

        do_cmd(1'b1, 0, 0, lat);
        chk("flag_latency", lat, 0);
        chk("flag_bit", board_out[0][0][7], 1);
        do_cmd(1'b0, 0, 0, lat);
        chk("flagged_reveal_rev", revealed_count, 0);
        do_cmd(1'b0, 7, 7, lat);
        chk("flood_rev", revealed_count, 62);
        chk("flood_skip_flag", board_out[0][0][6], 0);
        do_cmd(1'b1, 0, 0, lat);
        chk("unflag_bit", board_out[0][0][7], 0);
        do_cmd(1'b0, 0, 0, lat);
        chk("last_latency", lat, 64);
        chk("last_rev", revealed_count, 63);
        chk("last_win", win, 1);

        do_load(one_b);
        cmd_valid = 1; cmd_op = 0; cmd_row = 7; cmd_col = 7;
        tick();
        cmd_valid = 0;
        repeat (20) tick();
        chk("midsweep_busy", busy, 1);
        rst = 1;
        m_reset();
        #1;
        chk_board("rst_board", board_out, '0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rev", revealed_count, 0);
        tick();
        rst = 0;
        tick();
        do_load(one_b);
        do_cmd(1'b0, 2, 3, lat);
        chk("after_rst_latency", lat, 0);
        chk("after_rst_rev", revealed_count, 1);

        board_in = zero_b;
        load = 1; cmd_valid = 1; cmd_op = 0; cmd_row = 0; cmd_col = 0;
        tick();
        load = 0; cmd_valid = 0;
        chk("prio_done", done, 0);
        chk("prio_rev", revealed_count, 0);
        chk("prio_mines", mine_count, 0);
        chk("prio_ready", cmd_ready, 1);
        tick();
        chk("prio_done_late", done, 0);

        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                bombs = '0;
                for (int k = 0; k < int'($urandom_range(0, 10)); k++)
                    bombs[$urandom_range(0, 63)] = 1'b1;
                board_in = build_board(bombs, 1'b1);
                load = 1;
            end else begin
                load = 0;
            end
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = ($urandom_range(0, 3) == 0);
            cmd_row   = 3'($urandom_range(0, 7));
            cmd_col   = 3'($urandom_range(0, 7));
            tick();
        end
        load = 0;
        cmd_valid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/board_reveal_engine.md
# board_reveal_engine

Game-play stage directly downstream of the bomb placement/neighbour-count stage. It captures the finished 8x8 board and applies player commands: reveal a cell or toggle a flag. Revealing a zero-count cell triggers an iterative flood reveal. It also tracks the revealed-cell count and reports loss (bomb hit) and win. The VGA/render stage consumes `board_out` and the status flags.

## Interface

**Parameters**
- `N`, default 8: board dimension. Legal range 2..8. Row/col indices are 3 bits.

**Ports**
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `load`, input, 1: capture `board_in`. Honoured in states EMPTY, IDLE and OVER.
- `board_in[0:7][0:7]`, input, 9 each: board from the placement stage.
- `cmd_valid`, input, 1: command request.
- `cmd_ready`, output, 1: high only in IDLE.
- `cmd_op`, input, 1: 0 = reveal, 1 = flag toggle.
- `cmd_row`, `cmd_col`, input, 3 each: target cell.
- `board_out[0:7][0:7]`, output, 9 each: registered working board.
- `busy`, output, 1: high in SWEEP.
- `done`, output, 1: one-cycle pulse when a command completes.
- `hit_bomb`, output, 1: sticky; cleared by `load` or `rst`.
- `win`, output, 1: sticky; cleared by `load` or `rst`.
- `revealed_count`, output, 7: number of revealed cells.
- `mine_count`, output, 7: bombs counted at load.

## Operation

**Cell encoding**
- [3:0] neighbour count (0..8).
- [4] reserved, held 0.
- [5] bomb.
- [6] revealed.
- [7] flagged.
- [8] reserved, held 0.

**Load**
- Captures `board_in` with bits 8:6 and 4 forced to 0.
- `mine_count` = popcount of bit 5 over the N x N cells.
- `revealed_count` = 0; `hit_bomb` = 0; `win` = 0.
- Next state IDLE.
- `load` has priority over `cmd_valid`.

**States**
- **EMPTY**: reset state. Commands are ignored.
- **IDLE**: a command is accepted when `cmd_valid` is high.
  - Flag toggle on an unrevealed cell inverts bit 7. On a revealed cell it has no effect. `done` pulses either way.
  - Reveal on a revealed or flagged cell: no change, `done` pulses.
  - Reveal on a bomb: set bit 6, `hit_bomb` = 1, `done`, next state OVER.
  - Reveal on a cell with count != 0: set bit 6, `revealed_count` + 1, `done`.
  - Reveal on a cell with count == 0: set bit 6, `revealed_count` + 1, next state SWEEP with idx = 0 and changed = 0.
- **SWEEP**: evaluates one cell per cycle in row-major order, idx 0..63, where idx = row*8 + col.
  - Cells with row >= N or col >= N are skipped but still consume their cycle.
  - A cell is revealed when it is unrevealed, unflagged and non-bomb, and at least one in-bounds neighbour (of 8) is revealed, non-bomb, with count 0.
  - Updates are in place: later cells in the same sweep see earlier reveals.
  - Each reveal increments `revealed_count` and sets changed.
  - At idx 63: if changed, restart at idx 0 with changed cleared. Otherwise pulse `done`, run the win check and return to IDLE.
- **OVER**: commands are ignored; only `load` or `rst` exits.

**Win check**
- Evaluated at every `done`.
- If `revealed_count` + `mine_count` == N*N and `hit_bomb` == 0: `win` = 1, next state OVER.

**Arithmetic**
- `revealed_count` never exceeds N*N and never wraps.
- No cell is revealed twice.

## Timing

**Reset values**
- `board_out` all 0.
- `cmd_ready` 0, `busy` 0, `done` 0.
- `hit_bomb` 0, `win` 0.
- `revealed_count` 0, `mine_count` 0.
- State EMPTY.

**Load timing**
- Load takes effect at the sampling edge. `cmd_ready` is high from the next cycle.

**Command timing**
- A command is accepted at edge E0, where `cmd_valid` & `cmd_ready` is sampled.
- Non-flood commands: the cell update, `done`, `hit_bomb` and `win` are all registered at E0. `done` is high for the cycle after E0.
- Flood reveal: SWEEP cycles run at E1..E(64k), where k = number of sweeps (>= 1). `done` is registered at E(64k).
- `cmd_ready` is low throughout SWEEP; `cmd_valid` is ignored there.
- `rst` mid-SWEEP: asynchronous return to reset values immediately. No partial `done`.

## Test plan

- **All-zero board.** Load a board with N=8 and no bombs, then reveal (0,0).
  - Sweep 1 reveals all remaining cells; sweep 2 finds no change.
  - `done` 128 cycles after acceptance, `revealed_count` = 64, `mine_count` = 0, `win` = 1, state OVER, `cmd_ready` = 0.
- **Single-cell reveal.** Load a board with one bomb at (3,3) and correct counts, then reveal (2,3) (count 1).
  - Only (2,3) bit 6 is set, `revealed_count` = 1, `done` the cycle after E0, `busy` never high.
- **Bomb hit.** On the same board, reveal (3,3).
  - `hit_bomb` = 1, `done` pulses, `win` = 0.
  - A further `cmd_valid` changes nothing.
  - `load` restores IDLE with `hit_bomb` = 0.
- **Flag blocks reveal and flood.**
  - Flag (0,0), then reveal (0,0): no change, `revealed_count` = 0, `done`.
  - Then reveal (7,7) on the single-bomb board: the flood reveals 62 cells and stops at flagged (0,0); `revealed_count` = 62.
  - Unflag (0,0) and reveal it: `revealed_count` = 63, `win` = 1.
- **Reset mid-sweep.** Assert `rst` during SWEEP at idx 20.
  - Immediately: `board_out` all 0, `busy` = 0, `cmd_ready` = 0.
  - After `load`, a new reveal behaves normally.
- **Load priority.** Drive `load` and `cmd_valid` in the same IDLE cycle.
  - The board is reloaded, the command is ignored, and no `done` pulse occurs.
